arm7tdmi_multiply_iter: RTL and testbench

//  Iterative multiply / multiply-accumulate unit: MUL, MLA, UMULL, UMLAL, SMULL, SMLAL.

---
 rtl/arm7tdmi_multiply_iter.sv | 195 +++++++++++++++++++
 tb/tb_arm7tdmi_multiply_iter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/arm7tdmi_multiply_iter.sv
// Iterative MUL/MLA/UMULL/UMLAL/SMULL/SMLAL unit retiring RADIX_BITS of operand_b per cycle,
// with ARM7TDMI-style early termination and a start/busy/done/abort handshake.
module arm7tdmi_multiply_iter #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned RADIX_BITS = 8,
  parameter bit          EARLY_TERM = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic              mul_long,
  input  logic              mul_signed,
  input  logic              mul_accumulate,
  input  logic              mul_set_flags,
  input  logic [DATA_W-1:0] operand_a,
  input  logic [DATA_W-1:0] operand_b,
  input  logic [DATA_W-1:0] acc_hi,
  input  logic [DATA_W-1:0] acc_lo,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] result_hi,
  output logic [DATA_W-1:0] result_lo,
  output logic              negative,
  output logic              zero
);

  localparam int unsigned PW     = 2 * DATA_W;
  localparam int unsigned NCHUNK = DATA_W / RADIX_BITS;
  localparam int unsigned CNT_W  = $clog2(NCHUNK + 1);

  if ((DATA_W % RADIX_BITS) != 0) begin : g_bad_radix
    $error("DATA_W must be a multiple of RADIX_BITS");
  end

  typedef enum logic [1:0] {
    S_IDLE,
    S_MUL,
    S_EXT,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [PW-1:0]       a_sh_q, a_sh_d;
  logic [DATA_W-1:0]   b_sh_q, b_sh_d;
  logic [PW-1:0]       prod_q, prod_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          ext_q, ext_d;
  logic                long_q, long_d;
  logic                ones_ok_q, ones_ok_d;
  logic                flags_q, flags_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic [DATA_W-1:0]   result_hi_q, result_hi_d;
  logic [DATA_W-1:0]   result_lo_q, result_lo_d;
  logic                negative_q, negative_d;
  logic                zero_q, zero_d;

  logic [PW-1:0]       pp;
  logic [PW-1:0]       a_next;
  logic [DATA_W-1:0]   b_next;
  logic                last_chunk;
  logic                early;
  logic                corr_neg;

  // b is shifted arithmetically so the unretired top bits of operand_b
  // collapse to all-zero or all-one exactly when they are uniform.
  always_comb begin
    state_d     = state_q;
    a_sh_d      = a_sh_q;
    b_sh_d      = b_sh_q;
    prod_d      = prod_q;
    cnt_d       = cnt_q;
    ext_d       = ext_q;
    long_d      = long_q;
    ones_ok_d   = ones_ok_q;
    flags_d     = flags_q;
    result_hi_d = result_hi_q;
    result_lo_d = result_lo_q;
    negative_d  = negative_q;
    zero_d      = zero_q;
    busy_d      = 1'b0;
    done_d      = 1'b0;

    pp         = a_sh_q * PW'(b_sh_q[RADIX_BITS-1:0]);
    a_next     = a_sh_q << RADIX_BITS;
    b_next     = DATA_W'($signed(b_sh_q) >>> RADIX_BITS);
    last_chunk = (cnt_q == CNT_W'(NCHUNK));
    early      = EARLY_TERM && ((b_next == '0) || (ones_ok_q && (b_next == '1)));
    corr_neg   = ones_ok_q & b_next[DATA_W-1];

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          a_sh_d    = (mul_long && mul_signed) ? PW'($signed(operand_a)) : PW'(operand_a);
          b_sh_d    = operand_b;
          prod_d    = !mul_accumulate ? '0 :
                      mul_long ? {acc_hi, acc_lo} : {DATA_W'(0), acc_lo};
          cnt_d     = CNT_W'(1);
          ext_d     = 2'(mul_long) + 2'(mul_accumulate);
          long_d    = mul_long;
          ones_ok_d = mul_signed | ~mul_long;
          flags_d   = mul_set_flags;
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          prod_d = prod_q + pp;
          a_sh_d = a_next;
          b_sh_d = b_next;
          cnt_d  = cnt_q + CNT_W'(1);
          if (last_chunk || early) begin
            // Unretired bits were a sign extension of ones: subtract a << (j*S).
            if (corr_neg) prod_d = prod_q + pp - a_next;
            state_d = (ext_q == 2'd0) ? S_DONE : S_EXT;
          end
        end
      end
      S_EXT: begin
        if (abort) begin
          state_d = S_IDLE;
        end else begin
          ext_d = ext_q - 2'd1;
          if (ext_q == 2'd1) state_d = S_DONE;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    busy_d = (state_d == S_MUL) || (state_d == S_EXT);

    if (state_d == S_DONE) begin
      done_d      = 1'b1;
      result_lo_d = prod_d[DATA_W-1:0];
      result_hi_d = long_q ? prod_d[PW-1:DATA_W] : '0;
      if (flags_q) begin
        negative_d = long_q ? prod_d[PW-1] : prod_d[DATA_W-1];
        zero_d     = long_q ? (prod_d == '0) : (prod_d[DATA_W-1:0] == '0);
      end
    end
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      a_sh_q      <= '0;
      b_sh_q      <= '0;
      prod_q      <= '0;
      cnt_q       <= '0;
      ext_q       <= '0;
      long_q      <= 1'b0;
      ones_ok_q   <= 1'b0;
      flags_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      result_hi_q <= '0;
      result_lo_q <= '0;
      negative_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      a_sh_q      <= a_sh_d;
      b_sh_q      <= b_sh_d;
      prod_q      <= prod_d;
      cnt_q       <= cnt_d;
      ext_q       <= ext_d;
      long_q      <= long_d;
      ones_ok_q   <= ones_ok_d;
      flags_q     <= flags_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      result_hi_q <= result_hi_d;
      result_lo_q <= result_lo_d;
      negative_q  <= negative_d;
      zero_q      <= zero_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign result_hi = result_hi_q;
  assign result_lo = result_lo_q;
  assign negative  = negative_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_arm7tdmi_multiply_iter.sv
// Directed and randomized checks of arm7tdmi_multiply_iter: values, flags, latency and handshake.
module tb_arm7tdmi_multiply_iter;

  logic        clk, rst_n;
  logic        start, abort, ml, ms, ma, mf;
  logic [31:0] a, b, ahi, alo;
  logic        busy, done, neg, zero;
  logic [31:0] hi, lo;

  logic        s_start, s_ml, s_ms, s_ma, s_mf;
  logic [15:0] s_a, s_b, s_ahi, s_alo;
  logic        busy1, done1, neg1, zero1, busy0, done0, neg0, zero0;
  logic [15:0] hi1, lo1, hi0, lo0;

  int errors = 0;
  int checks = 0;

  arm7tdmi_multiply_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .mul_long(ml), .mul_signed(ms), .mul_accumulate(ma), .mul_set_flags(mf),
    .operand_a(a), .operand_b(b), .acc_hi(ahi), .acc_lo(alo),
    .busy(busy), .done(done), .result_hi(hi), .result_lo(lo),
    .negative(neg), .zero(zero)
  );

  arm7tdmi_multiply_iter #(.DATA_W(16), .RADIX_BITS(4), .EARLY_TERM(1'b1)) dut16_et1 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
    .mul_long(s_ml), .mul_signed(s_ms), .mul_accumulate(s_ma), .mul_set_flags(s_mf),
    .operand_a(s_a), .operand_b(s_b), .acc_hi(s_ahi), .acc_lo(s_alo),
    .busy(busy1), .done(done1), .result_hi(hi1), .result_lo(lo1),
    .negative(neg1), .zero(zero1)
  );

  arm7tdmi_multiply_iter #(.DATA_W(16), .RADIX_BITS(4), .EARLY_TERM(1'b0)) dut16_et0 (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(1'b0),
    .mul_long(s_ml), .mul_signed(s_ms), .mul_accumulate(s_ma), .mul_set_flags(s_mf),
    .operand_a(s_a), .operand_b(s_b), .acc_hi(s_ahi), .acc_lo(s_alo),
    .busy(busy0), .done(done0), .result_hi(hi0), .result_lo(lo0),
    .negative(neg0), .zero(zero0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one 32-bit op; cyc = cycle index after accept where done is seen (-1 on timeout).
  task automatic do_op32(input bit l, input bit s, input bit ac, input bit f,
                         input logic [31:0] oa, input logic [31:0] ob,
                         input logic [31:0] ohi, input logic [31:0] olo,
                         output int cyc, output bit busy_ok);
    ml = l; ms = s; ma = ac; mf = f; a = oa; b = ob; ahi = ohi; alo = olo;
    start = 1'b1;
    step();
    start = 1'b0;
    cyc = 1;
    busy_ok = 1'b1;
    while (done !== 1'b1 && cyc < 64) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      step();
      cyc++;
    end
    if (done !== 1'b1) cyc = -1;
    else if (busy !== 1'b0) busy_ok = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) step();
    checks++;
    if ({busy, done, neg, zero, hi, lo} !== 68'h0) begin
      errors++; $display("FAIL reset_hold got %h want 0", {busy, done, neg, zero, hi, lo});
    end
    rst_n = 1'b1;
    step();
    checks++;
    if ({busy, done, neg, zero, hi, lo} !== 68'h0) begin
      errors++; $display("FAIL reset_release got %h want 0", {busy, done, neg, zero, hi, lo});
    end
    checks++;
    if ({busy1, done1, hi1, lo1, busy0, done0, hi0, lo0} !== 68'h0) begin
      errors++; $display("FAIL reset_16 got %h want 0", {busy1, done1, hi1, lo1, busy0, done0, hi0, lo0});
    end
  endtask

  task automatic test_mla();
    int cyc; bit bok;
    do_op32(1'b0, 1'b0, 1'b1, 1'b1, 32'd5, 32'd7, 32'd0, 32'd10, cyc, bok);
    checks++; if (cyc !== 3) begin errors++; $display("FAIL mla_cycles got %0d want 3", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL mla_busy got %0b want 1", bok); end
    checks++; if ({hi, lo} !== 64'd45) begin errors++; $display("FAIL mla_value got %h want %h", {hi, lo}, 64'd45); end
    checks++; if ({neg, zero} !== 2'b00) begin errors++; $display("FAIL mla_flags got %b want 00", {neg, zero}); end
    step();
  endtask

  task automatic test_umlal();
    int cyc; bit bok;
    do_op32(1'b1, 1'b0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bok);
    checks++; if (cyc !== 7) begin errors++; $display("FAIL umlal_cycles got %0d want 7", cyc); end
    checks++; if (bok !== 1'b1) begin errors++; $display("FAIL umlal_busy got %0b want 1", bok); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000000) begin
      errors++; $display("FAIL umlal_value got %h want FFFFFFFE00000000", {hi, lo});
    end
    checks++; if ({neg, zero} !== 2'b10) begin errors++; $display("FAIL umlal_flags got %b want 10", {neg, zero}); end
    step();
  endtask

  task automatic test_signed_long();
    int cyc; bit bok;
    do_op32(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFFFC18, 32'd1000, 32'd0, 32'd0, cyc, bok);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL smull_cycles got %0d want 4", cyc); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFF0BDC0) begin
      errors++; $display("FAIL smull_value got %h want FFFFFFFFFFF0BDC0", {hi, lo});
    end
    checks++; if ({neg, zero} !== 2'b10) begin errors++; $display("FAIL smull_flags got %b want 10", {neg, zero}); end
    step();
    do_op32(1'b1, 1'b1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, cyc, bok);
    checks++; if (cyc !== 4) begin errors++; $display("FAIL smlal_cycles got %0d want 4", cyc); end
    checks++; if ({hi, lo} !== 64'h0) begin errors++; $display("FAIL smlal_value got %h want 0", {hi, lo}); end
    checks++; if ({neg, zero} !== 2'b01) begin errors++; $display("FAIL smlal_flags got %b want 01", {neg, zero}); end
    step();
    // flags disabled: new result lands, flags keep Z=1 N=0
    do_op32(1'b1, 1'b1, 1'b0, 1'b0, 32'hFFFFFC18, 32'd1000, 32'd0, 32'd0, cyc, bok);
    checks++; if ({hi, lo} !== 64'hFFFFFFFF_FFF0BDC0) begin
      errors++; $display("FAIL noflags_value got %h want FFFFFFFFFFF0BDC0", {hi, lo});
    end
    checks++; if ({neg, zero} !== 2'b01) begin errors++; $display("FAIL noflags_hold got %b want 01", {neg, zero}); end
    step();
  endtask

  task automatic test_short_and_top();
    int cyc; bit bok;
    do_op32(1'b0, 1'b1, 1'b0, 1'b1, 32'd3, 32'hFFFFFFFF, 32'h12345678, 32'd0, cyc, bok);
    checks++; if (cyc !== 2) begin errors++; $display("FAIL mul_neg_cycles got %0d want 2", cyc); end
    checks++; if ({hi, lo} !== 64'h00000000_FFFFFFFD) begin
      errors++; $display("FAIL mul_neg_value got %h want 00000000FFFFFFFD", {hi, lo});
    end
    checks++; if ({neg, zero} !== 2'b10) begin errors++; $display("FAIL mul_neg_flags got %b want 10", {neg, zero}); end
    step();
    do_op32(1'b1, 1'b0, 1'b0, 1'b1, 32'd2, 32'h80000000, 32'd0, 32'd0, cyc, bok);
    checks++; if (cyc !== 6) begin errors++; $display("FAIL umull_top_cycles got %0d want 6", cyc); end
    checks++; if ({hi, lo} !== 64'h00000001_00000000) begin
      errors++; $display("FAIL umull_top_value got %h want 0000000100000000", {hi, lo});
    end
    checks++; if ({neg, zero} !== 2'b00) begin errors++; $display("FAIL umull_top_flags got %b want 00", {neg, zero}); end
    step();
  endtask

  task automatic test_start_while_busy();
    int cyc;
    ml = 1'b1; ms = 1'b0; ma = 1'b1; mf = 1'b1;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ahi = 32'hFFFFFFFF; alo = 32'hFFFFFFFF;
    start = 1'b1;
    step();
    cyc = 1;
    ml = 1'b0; a = 32'd5; b = 32'd7; alo = 32'd10;
    while (done !== 1'b1 && cyc < 64) begin
      step();
      cyc++;
    end
    checks++; if (cyc !== 7) begin errors++; $display("FAIL busy_start_cycles got %0d want 7", cyc); end
    checks++; if ({hi, lo} !== 64'hFFFFFFFE_00000000) begin
      errors++; $display("FAIL busy_start_value got %h want FFFFFFFE00000000", {hi, lo});
    end
    step();
    start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL done_start_ignored busy got %0b want 0", busy); end
    step();
  endtask

  task automatic test_abort();
    bit saw_done;
    ml = 1'b1; ms = 1'b0; ma = 1'b1; mf = 1'b1;
    a = 32'd3; b = 32'hFFFFFFFF; ahi = 32'd0; alo = 32'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    abort = 1'b1;
    step();
    abort = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %0b want 0", busy); end
    saw_done = 1'b0;
    repeat (10) begin
      if (done === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL abort_no_done got %0b want 0", saw_done); end
    checks++; if ({hi, lo, neg, zero} !== {64'hFFFFFFFE_00000000, 2'b10}) begin
      errors++; $display("FAIL abort_hold got %h want %h", {hi, lo, neg, zero}, {64'hFFFFFFFE_00000000, 2'b10});
    end
    abort = 1'b1; start = 1'b1;
    step();
    abort = 1'b0; start = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle busy got %0b want 0", busy); end
    step();
  endtask

  task automatic test_reset_mid();
    bit saw_done;
    ml = 1'b1; ms = 1'b0; ma = 1'b1; mf = 1'b1;
    a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; ahi = 32'd0; alo = 32'd0;
    start = 1'b1;
    step();
    start = 1'b0;
    step();
    rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, neg, zero, hi, lo} !== 68'h0) begin
      errors++; $display("FAIL reset_mid got %h want 0", {busy, done, neg, zero, hi, lo});
    end
    step();
    rst_n = 1'b1;
    saw_done = 1'b0;
    repeat (10) begin
      if (done === 1'b1 || busy === 1'b1) saw_done = 1'b1;
      step();
    end
    checks++; if (saw_done !== 1'b0) begin errors++; $display("FAIL reset_mid_no_done got %0b want 0", saw_done); end
  endtask

  function automatic logic [31:0] model16(bit l, bit s, bit ac, logic [15:0] ma_, logic [15:0] mb_,
                                          logic [15:0] mhi, logic [15:0] mlo);
    logic signed [31:0] as_, bs_;
    logic [31:0] p;
    logic [15:0] sl;
    if (l && s) begin as_ = $signed(ma_); bs_ = $signed(mb_); end
    else begin as_ = {16'h0, ma_}; bs_ = {16'h0, mb_}; end
    p = as_ * bs_;
    if (l) return p + (ac ? {mhi, mlo} : 32'h0);
    sl = p[15:0] + (ac ? mlo : 16'h0);
    return {16'h0, sl};
  endfunction

  function automatic int k16(bit l, bit s, bit et, logic [15:0] mb_);
    logic [15:0] up, ones;
    if (!et) return 4;
    for (int j = 1; j < 4; j++) begin
      up = mb_ >> (4 * j);
      ones = 16'hFFFF >> (4 * j);
      if (up == 16'h0 || ((s || !l) && up == ones)) return j;
    end
    return 4;
  endfunction

  task automatic test_sweep16();
    int c, d1, d0, n1, n0;
    logic [31:0] exp_r, r1, r0;
    for (int i = 0; i < 2000; i++) begin
      s_ml = 1'($urandom); s_ms = 1'($urandom); s_ma = 1'($urandom); s_mf = 1'($urandom);
      s_a = 16'($urandom); s_ahi = 16'($urandom); s_alo = 16'($urandom);
      case ($urandom_range(3))
        0: s_b = 16'($urandom);
        1: s_b = 16'($urandom_range(0, 255));
        2: s_b = 16'hFFFF ^ 16'($urandom_range(0, 255));
        default: s_b = 16'hFFF0 | 16'($urandom_range(0, 15));
      endcase
      exp_r = model16(s_ml, s_ms, s_ma, s_a, s_b, s_ahi, s_alo);
      n1 = k16(s_ml, s_ms, 1'b1, s_b) + int'(s_ml) + int'(s_ma);
      n0 = k16(s_ml, s_ms, 1'b0, s_b) + int'(s_ml) + int'(s_ma);
      s_start = 1'b1;
      step();
      s_start = 1'b0;
      c = 1; d1 = -1; d0 = -1; r1 = '0; r0 = '0;
      while (c < 64) begin
        if (done1 === 1'b1 && d1 < 0) begin d1 = c; r1 = {hi1, lo1}; end
        if (done0 === 1'b1 && d0 < 0) begin d0 = c; r0 = {hi0, lo0}; end
        if (d1 >= 0 && d0 >= 0) break;
        step();
        c++;
      end
      checks++; if (d1 !== n1 + 1) begin errors++; $display("FAIL sweep_et1_cycles op%0d got %0d want %0d", i, d1, n1 + 1); end
      checks++; if (r1 !== exp_r) begin errors++; $display("FAIL sweep_et1_value op%0d got %h want %h", i, r1, exp_r); end
      checks++; if (d0 !== n0 + 1) begin errors++; $display("FAIL sweep_et0_cycles op%0d got %0d want %0d", i, d0, n0 + 1); end
      checks++; if (r0 !== exp_r) begin errors++; $display("FAIL sweep_et0_value op%0d got %h want %h", i, r0, exp_r); end
      step();
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; ml = 1'b0; ms = 1'b0; ma = 1'b0; mf = 1'b0;
    a = '0; b = '0; ahi = '0; alo = '0;
    s_start = 1'b0; s_ml = 1'b0; s_ms = 1'b0; s_ma = 1'b0; s_mf = 1'b0;
    s_a = '0; s_b = '0; s_ahi = '0; s_alo = '0;
    test_reset();
    test_mla();
    test_umlal();
    test_signed_long();
    test_short_and_top();
    test_start_while_busy();
    test_abort();
    test_reset_mid();
    test_sweep16();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
